// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 4-word lines and burst refill.
// Hits are combinational; misses stall the fetch until the whole line is filled.
module icache_dm #(
    parameter int WORD_SIZE   = 16,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 inv,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_rvalid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = LINES << OFFSET_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [WORD_SIZE-1:0]   data_mem [WORDS];
    logic [OFFSET_BITS-1:0] beat;
    logic                   inv_seen;

    logic [OFFSET_BITS-1:0] offset;
    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   hit;
    logic                   fill_beat;
    logic                   fill_last;

    assign offset     = i_address[OFFSET_BITS-1:0];
    assign index      = i_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign tag        = i_address[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS];
    assign fill_index = mem_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign fill_tag   = mem_addr[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS];

    // Lookups only count in IDLE, so a line is never reported as hit while it is being written.
    assign hit       = (state == IDLE) && valid[index] && (tag_mem[index] == tag);
    assign fill_beat = mem_req && mem_rvalid;
    assign fill_last = fill_beat && (&beat);

    assign i_ready = !i_readM || hit;
    assign i_data  = hit ? data_mem[{index, offset}] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            valid      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            beat       <= '0;
            inv_seen   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (i_readM && hit && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;

            case (state)
                IDLE: begin
                    if (i_readM && !hit) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_addr <= {i_address[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        beat     <= '0;
                        inv_seen <= 1'b0;
                        if (miss_count != 16'hFFFF)
                            miss_count <= miss_count + 16'd1;
                    end
                end
                FILL: begin
                    // An invalidate during the burst must keep the incoming line from becoming valid.
                    if (inv)
                        inv_seen <= 1'b1;
                    if (fill_beat) begin
                        beat <= beat + OFFSET_BITS'(1);
                        if (&beat) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (inv)
                valid <= '0;
            else if (fill_last && !inv_seen)
                valid[fill_index] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[{fill_index, beat}] <= mem_rdata;
            if (&beat)
                tag_mem[fill_index] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a behavioural memory answers line fills and a
// scoreboard queue holds the instruction expected for each fetch.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_readM = 1'b0;
    logic [15:0] i_address = 16'h0000;
    logic [15:0] i_data;
    logic        i_ready;
    logic        inv = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;
    int gap = 0;
    int rb = 0;
    int wt = 1;
    logic [15:0] sb [$];

    icache_dm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_readM    (i_readM),
        .i_address  (i_address),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .inv        (inv),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Memory: first beat one cycle after mem_req is seen, then 'gap' idle cycles between beats.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (!mem_req) begin
            rb = 0;
            wt = 1;
        end else if (rb < 4) begin
            if (wt > 0) begin
                wt = wt - 1;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(mem_addr + 16'(rb));
                rb = rb + 1;
                wt = gap;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_readM = 1'b0;
        inv     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!i_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic fetch(input logic [15:0] a, input int exp_stall, input string name);
        int          n = 0;
        logic [15:0] req_addr = 16'h0000;
        bit          seen = 1'b0;
        bit          chg = 1'b0;
        bit          req_low = 1'b0;
        logic [15:0] exp;
        @(negedge clk);
        i_readM   = 1'b1;
        i_address = a;
        sb.push_back(mem_word(a));
        #1;
        while (!i_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (!i_ready) begin
                if (!mem_req) req_low = 1'b1;
                else if (!seen) begin
                    seen     = 1'b1;
                    req_addr = mem_addr;
                end else if (mem_addr != req_addr) chg = 1'b1;
            end
        end
        check({name, "_ready"}, 32'(i_ready), 32'd1);
        exp = sb.pop_front();
        check({name, "_data"}, 32'(i_data), 32'(exp));
        check({name, "_stall"}, n, exp_stall);
        if (exp_stall > 0) begin
            check({name, "_memaddr"}, 32'(req_addr), 32'({a[15:2], 2'b00}));
            check({name, "_addrconst"}, 32'(chg), 32'd0);
            check({name, "_reqheld"}, 32'(req_low), 32'd0);
        end
        @(posedge clk);
        #1;
        i_readM = 1'b0;
    endtask

    initial begin
        int          n;
        logic [15:0] m0;

        do_reset();
        check("rst_ready", 32'(i_ready), 32'd1);
        check("rst_data", 32'(i_data), 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_memaddr", 32'(mem_addr), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_misses", 32'(miss_count), 32'd0);

        fetch(16'h0002, 6, "cold");
        check("cold_misses", 32'(miss_count), 32'd1);
        fetch(16'h0000, 0, "sp0");
        fetch(16'h0001, 0, "sp1");
        fetch(16'h0003, 0, "sp3");
        check("spatial_hits", 32'(hit_count), 32'd4);

        do_reset();
        fetch(16'h0000, 6, "conf0");
        fetch(16'h0020, 6, "conf1");
        fetch(16'h0000, 6, "conf2");
        check("conf_misses", 32'(miss_count), 32'd3);

        gap = 2;
        fetch(16'h0045, 12, "gapped");
        gap = 0;
        fetch(16'h0044, 0, "gap_w0");
        fetch(16'h0046, 0, "gap_w2");
        fetch(16'h0047, 0, "gap_w3");

        // Invalidate on the second beat of a fill: the line stays invalid and refetches.
        m0 = miss_count;
        @(negedge clk);
        i_readM   = 1'b1;
        i_address = 16'h0010;
        sb.push_back(mem_word(16'h0010));
        #1;
        check("inv_miss", 32'(i_ready), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            inv = (k == 3);
            #1;
        end
        check("inv_reqdrop", 32'(mem_req), 32'd0);
        check("inv_remiss", 32'(i_ready), 32'd0);
        wait_ready(n);
        check("inv_refill_stall", n, 32'd6);
        check("inv_data", 32'(i_data), 32'(sb.pop_front()));
        check("inv_misses", 32'(miss_count), 32'(m0 + 16'd2));
        @(posedge clk);
        #1;
        i_readM = 1'b0;

        // Invalidate together with a hit: served now, gone next cycle.
        @(negedge clk);
        i_readM   = 1'b1;
        i_address = 16'h0011;
        inv       = 1'b1;
        sb.push_back(mem_word(16'h0011));
        #1;
        check("invhit_ready", 32'(i_ready), 32'd1);
        check("invhit_data", 32'(i_data), 32'(sb.pop_front()));
        @(negedge clk);
        inv = 1'b0;
        sb.push_back(mem_word(16'h0011));
        #1;
        check("invhit_after", 32'(i_ready), 32'd0);
        wait_ready(n);
        check("invhit_refill", n, 32'd6);
        check("invhit_redata", 32'(i_data), 32'(sb.pop_front()));
        @(posedge clk);
        #1;
        i_readM = 1'b0;

        // Reset after beat 1 of a fill.
        @(negedge clk);
        i_readM   = 1'b1;
        i_address = 16'h0030;
        sb.push_back(mem_word(16'h0030));
        #1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) reset_n = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rstfill_memreq", 32'(mem_req), 32'd0);
        check("rstfill_hits", 32'(hit_count), 32'd0);
        check("rstfill_misses", 32'(miss_count), 32'd0);
        check("rstfill_remiss", 32'(i_ready), 32'd0);
        wait_ready(n);
        check("rstfill_stall", n, 32'd6);
        check("rstfill_data", 32'(i_data), 32'(sb.pop_front()));
        check("rstfill_count", 32'(miss_count), 32'd1);
        @(posedge clk);
        #1;
        i_readM = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
